// File: rtl/md_unit_param_if.sv
// Handshake and operand bundle between the EX stage and md_unit_param.
// The master drives operation requests and HI/LO writes; the slave returns status and HI/LO.
interface md_unit_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hilo_write;
  logic             hilo_sel;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, src_a, src_b, hilo_write, hilo_sel, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b, hilo_write, hilo_sel, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit_param.sv
// Multi-cycle mult/multu/div/divu unit owning HI/LO, with start/busy handshake and flush abort.
// Optional MD_EARLY_TERM_EN: divides by zero or with |dividend| < |divisor| commit after two edges.
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic          clk,
  input logic          rst,
  md_unit_param_if.slave bus
);
  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t               state_r, stateNxt_s;
  logic [CNT_W-1:0]     cnt_r, cntNxt_s;
  logic                 opSigned_r;
  logic [WIDTH-1:0]     opA_r, opB_r, magB_r, quo_r, rem_r, hi_r, lo_r;
  logic                 busy_r, done_r;
  logic [WIDTH-1:0]     hiNxt_s, loNxt_s;
  logic                 busyNxt_s, doneNxt_s;
  logic                 accept_s, commit_s, signedNew_s, earlyNew_s, skipDiv_s;
  logic [WIDTH-1:0]     magA_s, magBNew_s, quoFix_s, remFix_s;
  logic [WIDTH:0]       shifted_s, trial_s;
  logic [2*WIDTH-1:0]   extA_s, extB_s, prod_s;

  assign accept_s    = (state_r == IDLE) && bus.start && !bus.flush;
  assign commit_s    = !bus.flush && (((state_r == MUL) && (cnt_r == {CNT_W{1'b0}})) || (state_r == FIX));
  assign signedNew_s = !bus.md_op[0];
  assign magA_s      = (signedNew_s && bus.src_a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.src_a) : bus.src_a;
  assign magBNew_s   = (signedNew_s && bus.src_b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.src_b) : bus.src_b;

`ifdef MD_EARLY_TERM_EN
  logic early_r;
  assign earlyNew_s = bus.md_op[1] && ((bus.src_b == {WIDTH{1'b0}}) || (magA_s < magBNew_s));
  assign skipDiv_s  = early_r;

  // Remembers that the latched divide needs no iteration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      early_r <= 1'b0;
    end else if (accept_s) begin
      early_r <= earlyNew_s;
    end else begin
      early_r <= early_r;
    end
  end
`else
  assign earlyNew_s = 1'b0;
  assign skipDiv_s  = 1'b0;
`endif

  // Full-width product of the sign- or zero-extended operands.
  assign extA_s = {{WIDTH{opSigned_r & opA_r[WIDTH-1]}}, opA_r};
  assign extB_s = {{WIDTH{opSigned_r & opB_r[WIDTH-1]}}, opB_r};
  assign prod_s = extA_s * extB_s;

  // Restoring step: dividend bits shift out of quo_r into the partial remainder.
  assign shifted_s = {rem_r, quo_r[WIDTH-1]};
  assign trial_s   = shifted_s - {1'b0, magB_r};

  // The most-negative / -1 case needs no special path: magnitude division already yields src_a, 0.
  assign quoFix_s = (opSigned_r && (opA_r[WIDTH-1] ^ opB_r[WIDTH-1])) ? ({WIDTH{1'b0}} - quo_r) : quo_r;
  assign remFix_s = (opSigned_r && opA_r[WIDTH-1]) ? ({WIDTH{1'b0}} - rem_r) : rem_r;

  // State and counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= stateNxt_s;
      cnt_r   <= cntNxt_s;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    stateNxt_s = state_r;
    cntNxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s && bus.md_op[1]) begin
          stateNxt_s = DIV;
          cntNxt_s   = earlyNew_s ? {CNT_W{1'b0}} : CNT_W'(WIDTH - 1);
        end else if (accept_s) begin
          stateNxt_s = MUL;
          cntNxt_s   = CNT_W'(MUL_LAT - 1);
        end else begin
          stateNxt_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (bus.flush || (cnt_r == {CNT_W{1'b0}})) begin
          stateNxt_s = (bus.flush || (state_r == MUL)) ? IDLE : FIX;
          cntNxt_s   = {CNT_W{1'b0}};
        end else begin
          cntNxt_s   = cnt_r - CNT_W'(1'b1);
        end
      end
      FIX: begin
        stateNxt_s = IDLE;
        cntNxt_s   = {CNT_W{1'b0}};
      end
      default: begin
        stateNxt_s = IDLE;
        cntNxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Next HI/LO and status values; a commit outranks an mthi/mtlo request.
  always_comb begin
    hiNxt_s   = hi_r;
    loNxt_s   = lo_r;
    doneNxt_s = 1'b0;
    busyNxt_s = (stateNxt_s != IDLE);
    if (commit_s) begin
      doneNxt_s = 1'b1;
      if (state_r == MUL) begin
        hiNxt_s = prod_s[2*WIDTH-1:WIDTH];
        loNxt_s = prod_s[WIDTH-1:0];
      end else if (opB_r == {WIDTH{1'b0}}) begin
        hiNxt_s = opA_r;
        loNxt_s = {WIDTH{1'b1}};
      end else begin
        hiNxt_s = remFix_s;
        loNxt_s = quoFix_s;
      end
    end else if ((state_r == IDLE) && bus.hilo_write) begin
      if (bus.hilo_sel) begin
        hiNxt_s = bus.src_a;
      end else begin
        loNxt_s = bus.src_a;
      end
    end else begin
      doneNxt_s = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      hi_r   <= hiNxt_s;
      lo_r   <= loNxt_s;
      busy_r <= busyNxt_s;
      done_r <= doneNxt_s;
    end
  end

  // Operand latch and divide iteration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opSigned_r <= 1'b0;
      opA_r      <= {WIDTH{1'b0}};
      opB_r      <= {WIDTH{1'b0}};
      magB_r     <= {WIDTH{1'b0}};
      quo_r      <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      opSigned_r <= signedNew_s;
      opA_r      <= bus.src_a;
      opB_r      <= bus.src_b;
      magB_r     <= magBNew_s;
      quo_r      <= magA_s;
      rem_r      <= {WIDTH{1'b0}};
    end else if (state_r == DIV) begin
      if (skipDiv_s) begin
        quo_r <= {WIDTH{1'b0}};
        rem_r <= quo_r;
      end else if (!trial_s[WIDTH]) begin
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
        rem_r <= trial_s[WIDTH-1:0];
      end else begin
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
        rem_r <= shifted_s[WIDTH-1:0];
      end
    end else begin
      quo_r <= quo_r;
      rem_r <= rem_r;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_md_unit_param.sv
// Randomised and directed bench for md_unit_param (WIDTH=32, MUL_LAT=5) against a
// reference model built on native 64-bit multiply and integer divide/modulo.
module tb_md_unit_param;
  localparam int W  = 32;
  localparam int ML = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  md_unit_param_if #(.WIDTH(W)) bus ();
  md_unit_param #(.WIDTH(W), .MUL_LAT(ML)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Returns {hi, lo} for one operation.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    int     ia, ib, q, r;
    logic [63:0] u;
    case (op)
      2'b00: begin sa = int'(a); sb = int'(b); p = sa * sb; return p; end
      2'b01: begin u = {32'h0, a} * {32'h0, b}; return u; end
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        ia = int'(a); ib = int'(b); q = ia / ib; r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (!op[1]) return ML;
    ma = op[0] ? longint'({32'h0, a}) : longint'(int'(a));
    mb = op[0] ? longint'({32'h0, b}) : longint'(int'(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef MD_EARLY_TERM_EN
    if (b == 32'h0 || ma < mb) return 2;
`endif
    return W + 1 + int'(ma - ma);
  endfunction

  // Launch one operation (caller sits just after a negedge); returns at the negedge where done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busyCnt, output logic [31:0] oh, output logic [31:0] ol);
    bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; busyCnt = 0; oh = 32'h0; ol = 32'h0;
    for (int j = 0; j < 80 && lat < 0; j++) begin
      if (j > 0) @(negedge clk);
      if (bus.busy === 1'b1) busyCnt++;
      if (bus.done === 1'b1) begin lat = j; oh = bus.hi; ol = bus.lo; end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int lat, bc; logic [31:0] oh, ol;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bc, oh, ol);
    total++; if (oh !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", oh); end
    total++; if (ol !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h exp=ffffffeb", ol); end
    total++; if (lat !== ML) begin bad++; $display("FAIL mult_lat got=%0d exp=%0d", lat, ML); end
    total++; if (bc !== ML) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=%0d", bc, ML); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_div_directed();
    logic [1:0]  ops [4] = '{2'b11, 2'b10, 2'b10, 2'b10};
    logic [31:0] as  [4] = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] eh  [4] = '{32'd2, 32'hFFFF_FFFF, 32'd5, 32'h0};
    logic [31:0] el  [4] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int lat, bc, el_lat; logic [31:0] oh, ol;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bc, oh, ol);
      el_lat = ref_lat(ops[i], as[i], bs[i]);
      total++; if (oh !== eh[i]) begin bad++; $display("FAIL div%0d_hi got=%h exp=%h", i, oh, eh[i]); end
      total++; if (ol !== el[i]) begin bad++; $display("FAIL div%0d_lo got=%h exp=%h", i, ol, el[i]); end
      total++; if (lat !== el_lat) begin bad++; $display("FAIL div%0d_lat got=%0d exp=%0d", i, lat, el_lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_hilo_write();
    logic [31:0] loPrev;
    int j;
    loPrev = bus.lo;
    bus.hilo_write = 1'b1; bus.hilo_sel = 1'b1; bus.src_a = 32'h1234_5678;
    @(negedge clk);
    bus.hilo_write = 1'b0;
    total++; if (bus.hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_hi got=%h exp=12345678", bus.hi); end
    total++; if (bus.lo !== loPrev) begin bad++; $display("FAIL mthi_lo got=%h exp=%h", bus.lo, loPrev); end
    bus.hilo_write = 1'b1; bus.hilo_sel = 1'b0; bus.src_a = 32'hCAFE_F00D;
    @(negedge clk);
    bus.hilo_write = 1'b0;
    total++; if (bus.lo !== 32'hCAFE_F00D) begin bad++; $display("FAIL mtlo_lo got=%h exp=cafef00d", bus.lo); end
    // Write and start in the same idle cycle: write lands now, multu result later.
    bus.hilo_write = 1'b1; bus.hilo_sel = 1'b0; bus.src_a = 32'd2; bus.src_b = 32'd3;
    bus.md_op = 2'b01; bus.start = 1'b1;
    @(negedge clk);
    bus.hilo_write = 1'b0; bus.start = 1'b0;
    total++; if (bus.lo !== 32'd2) begin bad++; $display("FAIL write_start_lo got=%h exp=2", bus.lo); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL write_start_busy got=%b exp=1", bus.busy); end
    j = 0;
    while (bus.done !== 1'b1 && j < 20) begin @(negedge clk); j++; end
    total++; if (bus.lo !== 32'd6 || bus.hi !== 32'd0) begin bad++; $display("FAIL write_start_result got=%h_%h exp=0_6", bus.hi, bus.lo); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [31:0] oh, ol; logic [63:0] e;
    run_op(2'b11, 32'd1000, 32'd9, lat, bc, oh, ol);
    e = ref_result(2'b11, 32'd1000, 32'd9);
    total++; if ({oh, ol} !== e) begin bad++; $display("FAIL b2b_first got=%h exp=%h", {oh, ol}, e); end
    run_op(2'b00, 32'h0001_0003, 32'hFFFF_0005, lat, bc, oh, ol);
    e = ref_result(2'b00, 32'h0001_0003, 32'hFFFF_0005);
    total++; if ({oh, ol} !== e) begin bad++; $display("FAIL b2b_second got=%h exp=%h", {oh, ol}, e); end
    total++; if (lat !== ML) begin bad++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, ML); end
    @(negedge clk);
  endtask

  task automatic test_ignore_flush();
    int doneSeen, busyPre;
    bus.hilo_write = 1'b1; bus.hilo_sel = 1'b1; bus.src_a = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.hilo_sel = 1'b0; bus.src_a = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.hilo_write = 1'b0;
    doneSeen = 0; busyPre = 0;
    bus.start = 1'b1; bus.md_op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
      if (c == 10) busyPre = bus.busy;
      bus.start      = (c == 3);
      bus.md_op      = (c == 3) ? 2'b00 : 2'b11;
      bus.src_a      = (c == 4) ? 32'hDEAD_BEEF : 32'd3;
      bus.src_b      = 32'd4;
      bus.hilo_write = (c == 4);
      bus.hilo_sel   = 1'b0;
      bus.flush      = (c == 10);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    total++; if (busyPre !== 1) begin bad++; $display("FAIL flush_busy_before got=%0d exp=1", busyPre); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy_after got=%b exp=0", bus.busy); end
    total++; if (bus.hi !== 32'hA5A5_A5A5) begin bad++; $display("FAIL flush_hi got=%h exp=a5a5a5a5", bus.hi); end
    total++; if (bus.lo !== 32'h5A5A_5A5A) begin bad++; $display("FAIL flush_lo got=%h exp=5a5a5a5a", bus.lo); end
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    total++; if (doneSeen !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", doneSeen); end
  endtask

  task automatic test_flush_idle();
    int doneSeen;
    doneSeen = 0;
    bus.flush = 1'b1; bus.start = 1'b1; bus.md_op = 2'b00; bus.src_a = 32'd9; bus.src_b = 32'd9;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b exp=0", bus.busy); end
    for (int c = 0; c < 8; c++) begin
      if (bus.done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    total++; if (doneSeen !== 0) begin bad++; $display("FAIL flush_idle_done got=%0d exp=0", doneSeen); end
  endtask

  task automatic test_random();
    int lat, bc, el_lat; logic [31:0] oh, ol, a, b; logic [1:0] op; logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 20);
        2:       b = 32'h0;
        3:       b = 32'hFFFF_FFFF;
        default: begin a = $urandom_range(0, 50); b = $urandom_range(51, 200); end
      endcase
      run_op(op, a, b, lat, bc, oh, ol);
      e      = ref_result(op, a, b);
      el_lat = ref_lat(op, a, b);
      total++; if ({oh, ol} !== e) begin bad++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, {oh, ol}, e); end
      total++; if (lat !== el_lat) begin bad++; $display("FAIL rand%0d_lat got=%0d exp=%0d", i, lat, el_lat); end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.hilo_write = 1'b1; bus.hilo_sel = 1'b1; bus.src_a = 32'h1111_1111;
    @(negedge clk);
    bus.hilo_write = 1'b0;
    bus.start = 1'b1; bus.md_op = 2'b00; bus.src_a = 32'd6; bus.src_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL rst_mid_hi got=%h exp=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL rst_mid_lo got=%h exp=0", bus.lo); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.md_op = 2'b00; bus.src_a = 32'h0; bus.src_b = 32'h0;
    bus.hilo_write = 1'b0; bus.hilo_sel = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_mult();
    test_div_directed();
    test_hilo_write();
    test_back_to_back();
    test_ignore_flush();
    test_flush_idle();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
